img_bank_scheduler: RTL and testbench

//  Sequences the image-filter datapath against the HDMI scan-out. Owns one single-port

---
 rtl/img_bank_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_img_bank_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/img_bank_scheduler.sv
// img_bank_scheduler
// Ping-pong bank scheduler for the image-filter datapath. One single-port RAM is
// split into two banks: the display reads the front bank (o_bank) while the filter
// engine reads/writes the back bank. The display always wins the RAM port. One
// filter pass is started per frame, and banks swap at vsync once the pass is done.
//
// Build option: define IMG_SCHED_STATS_EN to enable the filter stall counter
// (o_stall_cnt). Without it o_stall_cnt is tied to zero.
//
// Handshake: a filter access is accepted in any cycle where flt_req and flt_gnt
// are both high. flt_gnt is combinational, so the filter must hold
// req/we/addr/wdata stable until it sees flt_gnt. Read data returns with a
// one-cycle rvalid pulse exactly MEM_LAT cycles after the accepted read; writes
// return nothing. The display side has no backpressure: disp_req is always served.
module img_bank_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_LAT    = 1,
  parameter int OVR_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  i_vsync,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  output logic                  disp_rvalid,
  input  logic                  flt_req,
  input  logic                  flt_we,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  input  logic [DATA_WIDTH-1:0] flt_wdata,
  output logic                  flt_gnt,
  output logic [DATA_WIDTH-1:0] flt_rdata,
  output logic                  flt_rvalid,
  output logic                  flt_start,
  input  logic                  flt_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  o_bank,
  output logic [OVR_W-1:0]      o_overrun,
  output logic [15:0]           o_stall_cnt,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 vsync_q;
  logic                 vs_fall;
  logic                 start_d, start_q;
  logic                 toggle_d;
  logic                 ovr_inc_d;
  logic                 bank_q;
  logic [OVR_W-1:0]     overrun_q;
  logic                 disp_rd_issue, flt_rd_issue;
  logic [MEM_LAT-1:0]   pv_q;   // read in flight per pipe stage
  logic [MEM_LAT-1:0]   po_q;   // owner per pipe stage: 1 = filter, 0 = display
  logic [DATA_WIDTH-1:0] disp_hold_q, flt_hold_q;

  assign vs_fall   = vsync_q & ~i_vsync;
  assign flt_start = start_q;
  assign o_bank    = bank_q;
  assign o_overrun = overrun_q;
  assign o_state   = state_q;

  // Registered vsync copy for falling-edge detection; idles high.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b1;
    else        vsync_q <= i_vsync;
  end

  // FSM state, start pulse, front-bank and overrun registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      bank_q    <= 1'b0;
      overrun_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      bank_q  <= bank_q ^ toggle_d;
      if (ovr_inc_d && (overrun_q != {OVR_W{1'b1}})) overrun_q <= overrun_q + 1'b1;
    end
  end

  // Next state: a pass completing in the same cycle as vsync counts as done-then-vsync.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    toggle_d  = 1'b0;
    ovr_inc_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (vs_fall) begin
          state_d = ST_RUN;
          start_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (flt_done && vs_fall) begin
          toggle_d = 1'b1;
          start_d  = 1'b1;
        end else if (flt_done) begin
          state_d = ST_DONE;
        end else if (vs_fall) begin
          ovr_inc_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (vs_fall) begin
          state_d  = ST_RUN;
          toggle_d = 1'b1;
          start_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port arbitration: display first, filter only while a pass is running.
  always_comb begin
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    flt_gnt       = 1'b0;
    disp_rd_issue = 1'b0;
    flt_rd_issue  = 1'b0;
    if (disp_req) begin
      mem_en        = 1'b1;
      mem_addr      = {bank_q, disp_addr};
      disp_rd_issue = 1'b1;
    end else if (flt_req && (state_q == ST_RUN)) begin
      flt_gnt      = 1'b1;
      mem_en       = 1'b1;
      mem_we       = flt_we;
      mem_addr     = {~bank_q, flt_addr};
      mem_wdata    = flt_wdata;
      flt_rd_issue = ~flt_we;
    end
  end

  // Read-return pipe: owner is tagged at issue, so a later bank swap cannot retag it.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      po_q <= '0;
    end else begin
      pv_q[0] <= disp_rd_issue | flt_rd_issue;
      po_q[0] <= flt_rd_issue;
      for (int i = 1; i < MEM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        po_q[i] <= po_q[i-1];
      end
    end
  end

  assign disp_rvalid = pv_q[MEM_LAT-1] & ~po_q[MEM_LAT-1];
  assign flt_rvalid  = pv_q[MEM_LAT-1] &  po_q[MEM_LAT-1];
  assign disp_rdata  = disp_rvalid ? mem_rdata : disp_hold_q;
  assign flt_rdata   = flt_rvalid  ? mem_rdata : flt_hold_q;

  // Capture returned data per owner so each read-data output holds between returns.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      disp_hold_q <= '0;
      flt_hold_q  <= '0;
    end else begin
      if (disp_rvalid) disp_hold_q <= mem_rdata;
      if (flt_rvalid)  flt_hold_q  <= mem_rdata;
    end
  end

`ifdef IMG_SCHED_STATS_EN
  logic [15:0] stall_q;

  // Blocked filter cycles within the current pass; restarts with each flt_start.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_d) begin
      stall_q <= '0;
    end else if ((state_q == ST_RUN) && flt_req && !flt_gnt && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_img_bank_scheduler.sv
// Directed bench for img_bank_scheduler (DATA_WIDTH=8, ADDR_WIDTH=16, MEM_LAT=1).
// Inputs change just after the falling clock edge; outputs are sampled 1ns later.
module tb_img_bank_scheduler;

  localparam int DW = 8;
  localparam int AW = 16;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          i_vsync;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  logic          flt_req;
  logic          flt_we;
  logic [AW-1:0] flt_addr;
  logic [DW-1:0] flt_wdata;
  logic          flt_gnt;
  logic [DW-1:0] flt_rdata;
  logic          flt_rvalid;
  logic          flt_start;
  logic          flt_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          o_bank;
  logic [7:0]    o_overrun;
  logic [15:0]   o_stall_cnt;
  logic [1:0]    o_state;

  int errors = 0;
  int checks = 0;

  img_bank_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LAT(1), .OVR_W(8)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .i_vsync(i_vsync),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .flt_req(flt_req), .flt_we(flt_we), .flt_addr(flt_addr), .flt_wdata(flt_wdata),
    .flt_gnt(flt_gnt), .flt_rdata(flt_rdata), .flt_rvalid(flt_rvalid),
    .flt_start(flt_start), .flt_done(flt_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .o_bank(o_bank), .o_overrun(o_overrun), .o_stall_cnt(o_stall_cnt), .o_state(o_state)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_vsync = 1'b1; disp_req = 1'b0; disp_addr = '0;
    flt_req = 1'b0; flt_we = 1'b0; flt_addr = '0; flt_wdata = '0;
    flt_done = 1'b0; mem_rdata = '0;
    step(); step(); settle();
    checks++; if (o_bank !== 1'b0) begin errors++; $display("FAIL reset_bank got=%b exp=0", o_bank); end
    checks++; if (o_overrun !== 8'd0) begin errors++; $display("FAIL reset_overrun got=%0d exp=0", o_overrun); end
    checks++; if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", o_state); end
    checks++; if ({flt_start, disp_rvalid, flt_rvalid, mem_en, mem_we} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=00000", {flt_start, disp_rvalid, flt_rvalid, mem_en, mem_we}); end
    checks++; if ({disp_rdata, flt_rdata} !== 16'h0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0000", {disp_rdata, flt_rdata}); end
    step(); rst_n = 1'b1;
    // Filter asks for the port but no frame has started.
    flt_req = 1'b1; flt_we = 1'b1; flt_addr = 16'd5; flt_wdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      step(); settle();
      checks++; if ({flt_gnt, mem_en, flt_start, o_bank} !== 4'b0) begin
        errors++; $display("FAIL idle_no_grant cyc=%0d got=%b exp=0000", i, {flt_gnt, mem_en, flt_start, o_bank}); end
    end
  endtask

  task automatic test_first_vsync();
    step(); i_vsync = 1'b0; settle();
    checks++; if (flt_start !== 1'b0 || flt_gnt !== 1'b0) begin
      errors++; $display("FAIL vsfall_cycle got start=%b gnt=%b exp 0 0", flt_start, flt_gnt); end
    step(); settle();
    checks++; if (flt_start !== 1'b1) begin errors++; $display("FAIL first_start got=%b exp=1", flt_start); end
    checks++; if (o_bank !== 1'b0) begin errors++; $display("FAIL first_bank got=%b exp=0", o_bank); end
    checks++; if (flt_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL first_write_ctl got gnt=%b en=%b we=%b exp 1 1 1", flt_gnt, mem_en, mem_we); end
    checks++; if (mem_addr !== 17'h10005) begin errors++; $display("FAIL first_write_addr got=%h exp=10005", mem_addr); end
    checks++; if (mem_wdata !== 8'h3C) begin errors++; $display("FAIL first_write_data got=%h exp=3c", mem_wdata); end
    step(); flt_req = 1'b0; settle();
    checks++; if (flt_start !== 1'b0) begin errors++; $display("FAIL start_pulse_width got=%b exp=0", flt_start); end
    checks++; if (flt_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got=%b exp=0", flt_rvalid); end
  endtask

  task automatic test_arbitration();
    step();
    disp_req = 1'b1; disp_addr = 16'h0123;
    flt_req = 1'b1; flt_we = 1'b0; flt_addr = 16'd7;
    settle();
    checks++; if (mem_addr !== 17'h00123 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
      errors++; $display("FAIL disp_prio_addr got addr=%h we=%b en=%b exp 00123 0 1", mem_addr, mem_we, mem_en); end
    checks++; if (flt_gnt !== 1'b0) begin errors++; $display("FAIL disp_prio_gnt got=%b exp=0", flt_gnt); end
    step(); disp_req = 1'b0; mem_rdata = 8'hA5; settle();
    checks++; if (disp_rvalid !== 1'b1 || disp_rdata !== 8'hA5) begin
      errors++; $display("FAIL disp_return got v=%b d=%h exp 1 a5", disp_rvalid, disp_rdata); end
    checks++; if (flt_gnt !== 1'b1 || mem_addr !== 17'h10007 || mem_we !== 1'b0) begin
      errors++; $display("FAIL flt_read_issue got gnt=%b addr=%h we=%b exp 1 10007 0", flt_gnt, mem_addr, mem_we); end
    step(); flt_req = 1'b0; mem_rdata = 8'h5A; settle();
    checks++; if (flt_rvalid !== 1'b1 || flt_rdata !== 8'h5A) begin
      errors++; $display("FAIL flt_return got v=%b d=%h exp 1 5a", flt_rvalid, flt_rdata); end
    checks++; if (disp_rvalid !== 1'b0 || disp_rdata !== 8'hA5) begin
      errors++; $display("FAIL disp_hold got v=%b d=%h exp 0 a5", disp_rvalid, disp_rdata); end
    step(); mem_rdata = 8'hFF; settle();
    checks++; if (flt_rvalid !== 1'b0 || flt_rdata !== 8'h5A) begin
      errors++; $display("FAIL flt_hold got v=%b d=%h exp 0 5a", flt_rvalid, flt_rdata); end
  endtask

  task automatic test_swap();
    step(); flt_done = 1'b1; i_vsync = 1'b1;
    flt_req = 1'b1; flt_we = 1'b1; flt_addr = 16'd9; flt_wdata = 8'h11;
    step(); flt_done = 1'b0; settle();
    checks++; if (o_state !== 2'd2) begin errors++; $display("FAIL done_state got=%0d exp=2", o_state); end
    checks++; if (flt_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL done_no_grant got gnt=%b en=%b exp 0 0", flt_gnt, mem_en); end
    step(); i_vsync = 1'b0; settle();
    checks++; if (o_bank !== 1'b0 || flt_start !== 1'b0) begin
      errors++; $display("FAIL pre_swap got bank=%b start=%b exp 0 0", o_bank, flt_start); end
    step(); i_vsync = 1'b1; settle();
    checks++; if (o_bank !== 1'b1 || flt_start !== 1'b1) begin
      errors++; $display("FAIL swap got bank=%b start=%b exp 1 1", o_bank, flt_start); end
    checks++; if (flt_gnt !== 1'b1 || mem_addr !== 17'h00009) begin
      errors++; $display("FAIL swap_back_bank got gnt=%b addr=%h exp 1 00009", flt_gnt, mem_addr); end
  endtask

  task automatic test_overrun();
    step(); flt_req = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      step(); i_vsync = 1'b0;
      step(); i_vsync = 1'b1; settle();
      checks++; if (flt_start !== 1'b0 || o_bank !== 1'b1 || o_overrun !== n[7:0]) begin
        errors++; $display("FAIL overrun_%0d got start=%b bank=%b ovr=%0d exp 0 1 %0d", n, flt_start, o_bank, o_overrun, n); end
    end
    checks++; if (o_state !== 2'd1) begin errors++; $display("FAIL overrun_state got=%0d exp=1", o_state); end
  endtask

  task automatic test_back_to_back();
    // Ten filter requests shadowed by display traffic.
    for (int i = 0; i < 10; i++) begin
      step(); disp_req = 1'b1; disp_addr = i[AW-1:0]; flt_req = 1'b1; flt_we = 1'b0;
    end
    step(); disp_req = 1'b0; flt_req = 1'b0; settle();
`ifdef IMG_SCHED_STATS_EN
    checks++; if (o_stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_count got=%0d exp=10", o_stall_cnt); end
`else
    checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_tied got=%0d exp=0", o_stall_cnt); end
`endif
    // Done and vsync fall together: swap and restart.
    step(); flt_done = 1'b1; i_vsync = 1'b0;
    step(); flt_done = 1'b0; i_vsync = 1'b1; settle();
    checks++; if (o_bank !== 1'b0 || flt_start !== 1'b1) begin
      errors++; $display("FAIL same_cycle_swap got bank=%b start=%b exp 0 1", o_bank, flt_start); end
    checks++; if (o_overrun !== 8'd2 || o_state !== 2'd1) begin
      errors++; $display("FAIL same_cycle_state got ovr=%0d st=%0d exp 2 1", o_overrun, o_state); end
    checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_clear got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_reset_midflight();
    step(); disp_req = 1'b1; disp_addr = 16'd1;
    step(); disp_req = 1'b0; mem_rdata = 8'h77; settle(); rst_n = 1'b0; settle();
    checks++; if (disp_rvalid !== 1'b0 || disp_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_flush got v=%b d=%h exp 0 00", disp_rvalid, disp_rdata); end
    checks++; if (o_bank !== 1'b0 || o_overrun !== 8'd0 || o_state !== 2'd0) begin
      errors++; $display("FAIL reset_mid_state got bank=%b ovr=%0d st=%0d exp 0 0 0", o_bank, o_overrun, o_state); end
    step(); rst_n = 1'b1;
    step(); settle();
    checks++; if (disp_rvalid !== 1'b0) begin errors++; $display("FAIL reset_no_late_rvalid got=%b exp=0", disp_rvalid); end
  endtask

  initial begin
    test_reset();
    test_first_vsync();
    test_arbitration();
    test_swap();
    test_overrun();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
